mc_req_buf: RTL and testbench

- Request-side shim between the vector-add personality unit and its memory-controller (MC) port.
- Accepts load/store requests issued against registered (one-cycle-late) stall signals, buffers them in program order and forwards them to the MC honouring the MC's read/write stalls.
- Tracks outstanding loads against a cap and provides a quiesce handshake so the personality can confirm all traffic is done before reporting sum_vld.

---
 rtl/mc_req_pkg.sv | 16 +
 rtl/mc_req_fifo.sv | 38 +++
 rtl/mc_req_buf.sv | 129 ++++++++++++
 tb/tb_mc_req_buf.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_req_pkg.sv
// mc_req_pkg: shared request entry, FSM state and helpers for the MC request buffer.
package mc_req_pkg;
  localparam int REQ_W = 116;
  localparam int VADR_W = 48;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic typ;
    logic [VADR_W-1:0] vadr;
    logic [1:0] size;
    logic flush;
    logic [63:0] wrd_rdctl;
  } req_t;
  function automatic logic [31:0] sat_inc(logic [31:0] v, logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/mc_req_fifo.sv
// mc_req_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// A push on a full FIFO is taken only if a pop frees the slot in the same cycle.
module mc_req_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 116
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/mc_req_buf.sv
// mc_req_buf: in-order load/store request buffer between the personality and its MC port.
// Optional MC_REQ_BUF_STATS_EN adds saturating issue/blocked statistics counters.
module mc_req_buf
  import mc_req_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SKID = 4,
  parameter int MAX_OUTST = 256,
  parameter int CNT_W = 9
) (
  input  logic clk,
  input  logic reset_n,
  input  logic up_req_ld,
  input  logic up_req_st,
  input  logic [47:0] up_req_vadr,
  input  logic [1:0] up_req_size,
  input  logic up_req_flush,
  input  logic [63:0] up_req_wrd_rdctl,
  output logic up_rd_rq_stall,
  output logic up_wr_rq_stall,
  output logic mc_req_ld,
  output logic mc_req_st,
  output logic [47:0] mc_req_vadr,
  output logic [1:0] mc_req_size,
  output logic mc_req_flush,
  output logic [63:0] mc_req_wrd_rdctl,
  input  logic mc_rd_rq_stall,
  input  logic mc_wr_rq_stall,
  input  logic mc_rsp_push,
  input  logic quiesce_req,
  output logic quiesce_ack,
  output logic [CNT_W-1:0] outst_cnt,
  output logic err,
  output logic [31:0] stat_ld,
  output logic [31:0] stat_st,
  output logic [31:0] stat_blk
);
  localparam int CW = $clog2(DEPTH) + 1;
  req_t din, head;
  state_t state, state_nxt;
  logic [CW-1:0] count;
  logic push, full, empty, rd_stl_q, wr_stl_q, head_blk, issue, issue_ld, rsp_ok, up_stl, run;
  assign push = up_req_ld | up_req_st;
  assign din = {up_req_st, up_req_vadr, up_req_size, up_req_flush, up_req_wrd_rdctl};
  mc_req_fifo #(.DEPTH(DEPTH), .W(REQ_W)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(issue),
    .din(din),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // Loads also wait on the outstanding cap; the head blocks everything behind it.
  assign head_blk = head.typ ? wr_stl_q : (rd_stl_q || outst_cnt >= CNT_W'(MAX_OUTST));
  assign issue = !empty && !head_blk;
  assign issue_ld = issue && !head.typ;
  assign rsp_ok = mc_rsp_push && outst_cnt != '0;
  assign up_rd_rq_stall = up_stl;
  assign up_wr_rq_stall = up_stl;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_stl_q <= 1'b0;
      wr_stl_q <= 1'b0;
      up_stl <= 1'b0;
      mc_req_ld <= 1'b0;
      mc_req_st <= 1'b0;
      mc_req_vadr <= '0;
      mc_req_size <= '0;
      mc_req_flush <= 1'b0;
      mc_req_wrd_rdctl <= '0;
      outst_cnt <= '0;
      err <= 1'b0;
    end else begin
      rd_stl_q <= mc_rd_rq_stall;
      wr_stl_q <= mc_wr_rq_stall;
      up_stl <= count >= CW'(DEPTH - SKID) || !run;
      mc_req_ld <= issue_ld;
      mc_req_st <= issue && head.typ;
      if (issue) begin
        mc_req_vadr <= head.vadr;
        mc_req_size <= head.size;
        mc_req_flush <= head.flush;
        mc_req_wrd_rdctl <= head.wrd_rdctl;
      end
      outst_cnt <= outst_cnt + CNT_W'(issue_ld) - CNT_W'(rsp_ok);
      err <= err || (push && full && !issue) || (mc_rsp_push && outst_cnt == '0);
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RUN;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: state_nxt = quiesce_req ? DRAIN : RUN;
      DRAIN: state_nxt = !quiesce_req ? RUN : (empty && outst_cnt == '0) ? DONE : DRAIN;
      DONE: state_nxt = quiesce_req ? DONE : RUN;
      default: state_nxt = RUN;
    endcase
  end
  always_comb begin
    run = state == RUN;
    quiesce_ack = state == DONE && quiesce_req;
  end
`ifdef MC_REQ_BUF_STATS_EN
  logic clr;
  assign clr = run && quiesce_req;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stat_ld <= '0;
      stat_st <= '0;
      stat_blk <= '0;
    end else if (clr) begin
      stat_ld <= '0;
      stat_st <= '0;
      stat_blk <= '0;
    end else begin
      stat_ld <= sat_inc(stat_ld, issue_ld);
      stat_st <= sat_inc(stat_st, issue && head.typ);
      stat_blk <= sat_inc(stat_blk, !empty && head_blk);
    end
`else
  assign stat_ld = '0;
  assign stat_st = '0;
  assign stat_blk = '0;
`endif
endmodule

// File: tb/tb_mc_req_buf.sv
// tb_mc_req_buf: scoreboard bench; stimulus queues expected MC requests, a negedge monitor checks them.
module tb_mc_req_buf;
  logic clk = 0, reset_n = 0;
  logic up_req_ld = 0, up_req_st = 0, up_req_flush = 0;
  logic [47:0] up_req_vadr = '0;
  logic [1:0] up_req_size = '0;
  logic [63:0] up_req_wrd_rdctl = '0;
  logic up_rd_rq_stall, up_wr_rq_stall, mc_req_ld, mc_req_st, mc_req_flush;
  logic [47:0] mc_req_vadr;
  logic [1:0] mc_req_size;
  logic [63:0] mc_req_wrd_rdctl;
  logic mc_rd_rq_stall = 0, mc_wr_rq_stall = 0, mc_rsp_push = 0, quiesce_req = 0;
  logic quiesce_ack, err;
  logic [8:0] outst_cnt;
  logic [31:0] stat_ld, stat_st, stat_blk;
  logic [115:0] exp_q[$];
  logic [115:0] e, got;
  int vec = 0, mis = 0, n_ld = 0, n_st = 0, b_ld, b_st;

  mc_req_buf dut (
    .clk(clk), .reset_n(reset_n),
    .up_req_ld(up_req_ld), .up_req_st(up_req_st), .up_req_vadr(up_req_vadr),
    .up_req_size(up_req_size), .up_req_flush(up_req_flush), .up_req_wrd_rdctl(up_req_wrd_rdctl),
    .up_rd_rq_stall(up_rd_rq_stall), .up_wr_rq_stall(up_wr_rq_stall),
    .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st), .mc_req_vadr(mc_req_vadr),
    .mc_req_size(mc_req_size), .mc_req_flush(mc_req_flush), .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
    .mc_rd_rq_stall(mc_rd_rq_stall), .mc_wr_rq_stall(mc_wr_rq_stall), .mc_rsp_push(mc_rsp_push),
    .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack), .outst_cnt(outst_cnt), .err(err),
    .stat_ld(stat_ld), .stat_st(stat_st), .stat_blk(stat_blk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vec++;
    if (act !== req) begin
      mis++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic st, input logic [47:0] a, input logic [1:0] sz,
                      input logic fl, input logic [63:0] d, input logic keep = 1'b1);
    up_req_ld = !st;
    up_req_st = st;
    up_req_vadr = a;
    up_req_size = sz;
    up_req_flush = fl;
    up_req_wrd_rdctl = d;
    if (keep) exp_q.push_back({st, a, sz, fl, d});
    tick();
    up_req_ld = 0;
    up_req_st = 0;
  endtask

  task automatic rsp(input int n);
    repeat (n) begin
      mc_rsp_push = 1;
      tick();
    end
    mc_rsp_push = 0;
  endtask

  always @(negedge clk)
    if (reset_n && (mc_req_ld || mc_req_st)) begin
      n_ld += int'(mc_req_ld);
      n_st += int'(mc_req_st);
      vec++;
      got = {mc_req_st, mc_req_vadr, mc_req_size, mc_req_flush, mc_req_wrd_rdctl};
      if (mc_req_ld && mc_req_st) begin
        mis++;
        $display("FAIL mc_req both: ld=%0b st=%0b want one-hot", mc_req_ld, mc_req_st);
      end else if (exp_q.size() == 0) begin
        mis++;
        $display("FAIL mc_req unexpected: got %0h want none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          mis++;
          $display("FAIL mc_req order: got %0h want %0h", got, e);
        end
      end
    end

  initial begin
    tick(2);
    chk("rst mc_req_ld", mc_req_ld, 0);
    chk("rst up_stall", {up_rd_rq_stall, up_wr_rq_stall}, 0);
    chk("rst outst", outst_cnt, 0);
    chk("rst err/ack", {err, quiesce_ack}, 0);
    reset_n = 1;
    tick(2);
    // 10 back-to-back loads, 2-cycle latency
    for (int i = 0; i < 10; i++) begin
      push(0, 48'h1000 + 48'(i), 2'(i), 1'(i), 64'hA000 + 64'(i));
      if (i == 0) chk("lat c1", mc_req_ld, 0);
      if (i == 1) chk("lat c2", mc_req_ld, 1);
    end
    tick(4);
    chk("outst 10", outst_cnt, 10);
    chk("n_ld 10", n_ld, 10);
    rsp(10);
    tick();
    chk("outst 0", outst_cnt, 0);
    // upstream stall threshold with MC read stalled
    mc_rd_rq_stall = 1;
    tick(2);
    for (int i = 0; i < 12; i++) push(0, 48'h2000 + 48'(i), 2'd1, 0, 64'(i));
    chk("up stall @12", up_rd_rq_stall, 0);
    push(0, 48'h200C, 2'd2, 1, 64'hC);
    chk("up_rd stall", up_rd_rq_stall, 1);
    chk("up_wr stall", up_wr_rq_stall, 1);
    push(0, 48'h200D, 2'd3, 0, 64'hD);
    chk("no err skid", err, 0);
    mc_rd_rq_stall = 0;
    tick(20);
    chk("outst 14", outst_cnt, 14);
    rsp(14);
    tick(2);
    chk("stall cleared", up_rd_rq_stall, 0);
    // blocked load head holds a store behind it
    b_ld = n_ld;
    b_st = n_st;
    mc_rd_rq_stall = 1;
    tick(2);
    push(0, 48'h3000, 2'd0, 0, 64'h33);
    push(1, 48'h3008, 2'd3, 1, 64'hDEADBEEF);
    tick(5);
    chk("st held", n_st - b_st, 0);
    mc_rd_rq_stall = 0;
    tick(5);
    chk("st released", n_st - b_st, 1);
    chk("ld released", n_ld - b_ld, 1);
    rsp(1);
    // outstanding cap
    b_ld = n_ld;
    for (int i = 0; i < 258; i++) push(0, 48'h40000 + 48'(i), 2'(i), 0, ~64'(i));
    tick(5);
    chk("cap issued", n_ld - b_ld, 256);
    chk("cap outst", outst_cnt, 256);
    rsp(1);
    tick(3);
    chk("cap +1", n_ld - b_ld, 257);
    chk("cap outst2", outst_cnt, 256);
    rsp(257);
    tick(3);
    chk("cap all", n_ld - b_ld, 258);
    chk("cap drained", outst_cnt, 0);
    // quiesce with 2 outstanding and 3 queued
    push(0, 48'h5000, 0, 0, 64'h50);
    push(0, 48'h5001, 0, 0, 64'h51);
    tick(4);
    chk("q outst2", outst_cnt, 2);
    mc_rd_rq_stall = 1;
    tick(2);
    for (int i = 0; i < 3; i++) push(0, 48'h5100 + 48'(i), 1, 1, 64'h60 + 64'(i));
    quiesce_req = 1;
    tick(2);
    chk("q up stall", up_rd_rq_stall, 1);
    chk("q ack early", quiesce_ack, 0);
    mc_rd_rq_stall = 0;
    tick(6);
    chk("q outst5", outst_cnt, 5);
    chk("q ack pend", quiesce_ack, 0);
    rsp(4);
    tick(2);
    chk("q ack 4rsp", quiesce_ack, 0);
    rsp(1);
    tick();
    chk("q ack", quiesce_ack, 1);
    quiesce_req = 0;
    #1;
    chk("q ack drop", quiesce_ack, 0);
    tick(2);
    chk("q stall drop", up_rd_rq_stall, 0);
    // overflow, then asynchronous reset mid-traffic
    mc_rd_rq_stall = 1;
    tick(2);
    for (int i = 0; i < 17; i++) push(0, 48'h6000 + 48'(i), 2, 0, 64'h70 + 64'(i), 1'(i < 16));
    chk("ovf err", err, 1);
    mc_rd_rq_stall = 0;
    tick(4);
    chk("traffic live", mc_req_ld, 1);
    reset_n = 0;
    #1;
    chk("arst ld", mc_req_ld, 0);
    chk("arst err", err, 0);
    chk("arst outst", outst_cnt, 0);
    chk("arst vadr", mc_req_vadr, 0);
    chk("arst stall", up_rd_rq_stall, 0);
    exp_q.delete();
    tick(2);
    reset_n = 1;
    tick(2);
    rsp(1);
    chk("rsp0 err", err, 1);
    chk("rsp0 outst", outst_cnt, 0);
    tick(3);
    chk("err sticky", err, 1);
    chk("queue drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
